ysyx_23060332_lsu: RTL and testbench



---
 rtl/ysyx_23060332_lsu_pkg.sv | 46 ++++
 rtl/ysyx_23060332_lsu_if.sv | 52 +++++
 rtl/ysyx_23060332_lsu_align.sv | 56 +++++
 rtl/ysyx_23060332_lsu.sv | 130 +++++++++++++
 tb/tb_ysyx_23060332_lsu.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_23060332_lsu_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_23060332_lsu_pkg : funct3 codes, LSU states and request legality check
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ysyx_23060332_lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } lsu_state_e;

  // Returns 1 when the request must be answered with an error and no access.
  function automatic logic lsu_req_err(input logic       is_load,
                                       input logic       is_store,
                                       input logic [2:0] funct3,
                                       input logic [1:0] addr_lo);
    logic bad_op;
    logic bad_align;
    bad_op = (is_load == is_store);
    if (is_load && !(funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU}))
      bad_op = 1'b1;
    if (is_store && !(funct3 inside {F3_SB, F3_SH, F3_SW}))
      bad_op = 1'b1;
    bad_align = ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
                ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));
    return bad_op || bad_align;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ysyx_23060332_lsu_if.sv
// ---------------------------------------------------------------------------
// ysyx_23060332_lsu_if : execute-side request/response and data-memory port
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface ysyx_23060332_lsu_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MASK_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_is_load;
  logic              req_is_store;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;
  logic              mem_ren;
  logic [ADDR_W-1:0] mem_raddr;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [MASK_W-1:0] mem_wmask;

  // Environment side: execute stage, writeback and memory
  modport master (
    output req_valid, req_is_load, req_is_store, req_funct3, req_addr, req_wdata,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_err,
    output resp_ready,
    input  mem_ren, mem_raddr, mem_wen, mem_waddr, mem_wdata, mem_wmask,
    output mem_rdata
  );

  // LSU side
  modport slave (
    input  req_valid, req_is_load, req_is_store, req_funct3, req_addr, req_wdata,
    output req_ready,
    output resp_valid, resp_rdata, resp_err,
    input  resp_ready,
    output mem_ren, mem_raddr, mem_wen, mem_waddr, mem_wdata, mem_wmask,
    input  mem_rdata
  );
endinterface

`default_nettype wire

// File: rtl/ysyx_23060332_lsu_align.sv
// ---------------------------------------------------------------------------
// ysyx_23060332_lsu_align : byte-lane store shift/mask and load extract/extend
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ysyx_23060332_lsu_align
  import ysyx_23060332_lsu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int MASK_W = 8
) (
  input  logic [1:0]        offset,
  input  logic [2:0]        funct3,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] st_data,
  output logic [MASK_W-1:0] st_mask,
  output logic [DATA_W-1:0] ld_data
);

  logic [4:0]        shamt;
  logic [3:0]        lanes;
  logic [3:0]        lanes_sh;
  logic [DATA_W-1:0] ld_word;

  assign shamt    = {offset, 3'b000};
  assign st_data  = din << shamt;
  assign ld_word  = din >> shamt;
  assign lanes_sh = lanes << offset;
  // Only the four word lanes can ever be enabled.
  assign st_mask  = {{(MASK_W-4){1'b0}}, lanes_sh};

  always_comb begin
    lanes = 4'b1111;
    case (funct3[1:0])
      2'b00:   lanes = 4'b0001;
      2'b01:   lanes = 4'b0011;
      default: lanes = 4'b1111;
    endcase
  end

  always_comb begin
    ld_data = '0;
    case (funct3)
      F3_LB:   ld_data = {{(DATA_W-8){ld_word[7]}}, ld_word[7:0]};
      F3_LH:   ld_data = {{(DATA_W-16){ld_word[15]}}, ld_word[15:0]};
      F3_LW:   ld_data = ld_word;
      F3_LBU:  ld_data = {{(DATA_W-8){1'b0}}, ld_word[7:0]};
      F3_LHU:  ld_data = {{(DATA_W-16){1'b0}}, ld_word[15:0]};
      default: ld_data = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/ysyx_23060332_lsu.sv
// ---------------------------------------------------------------------------
// ysyx_23060332_lsu : one-at-a-time load/store unit driving a registered memory
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ysyx_23060332_lsu
  import ysyx_23060332_lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MASK_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  ysyx_23060332_lsu_if.slave     bus
);

  lsu_state_e        state;
  logic              op_load;
  logic [ADDR_W-1:0] addr;
  logic [2:0]        funct3;
  logic [DATA_W-1:0] wdata;
  logic              ready;
  logic              valid;
  logic              err;
  logic [DATA_W-1:0] rdata;

  logic [DATA_W-1:0] st_data;
  logic [MASK_W-1:0] st_mask;
  logic [DATA_W-1:0] ld_data;
  logic [DATA_W-1:0] st_ld_unused;
  logic [DATA_W-1:0] ld_st_data_unused;
  logic [MASK_W-1:0] ld_st_mask_unused;
  logic              rd_strobe;
  logic              wr_strobe;

  ysyx_23060332_lsu_align #(.DATA_W(DATA_W), .MASK_W(MASK_W)) u_align_st (
    .offset  (addr[1:0]),
    .funct3  (funct3),
    .din     (wdata),
    .st_data (st_data),
    .st_mask (st_mask),
    .ld_data (st_ld_unused)
  );

  ysyx_23060332_lsu_align #(.DATA_W(DATA_W), .MASK_W(MASK_W)) u_align_ld (
    .offset  (addr[1:0]),
    .funct3  (funct3),
    .din     (bus.mem_rdata),
    .st_data (ld_st_data_unused),
    .st_mask (ld_st_mask_unused),
    .ld_data (ld_data)
  );

  // Strobes exist only in REQ; everything else on the memory port idles at zero.
  assign rd_strobe     = (state == S_REQ) &&  op_load;
  assign wr_strobe     = (state == S_REQ) && !op_load;
  assign bus.mem_ren   = rd_strobe;
  assign bus.mem_wen   = wr_strobe;
  assign bus.mem_raddr = rd_strobe ? {addr[ADDR_W-1:2], 2'b00} : '0;
  assign bus.mem_waddr = wr_strobe ? {addr[ADDR_W-1:2], 2'b00} : '0;
  assign bus.mem_wdata = wr_strobe ? st_data : '0;
  assign bus.mem_wmask = wr_strobe ? st_mask : '0;

  assign bus.req_ready  = ready;
  assign bus.resp_valid = valid;
  assign bus.resp_err   = err;
  assign bus.resp_rdata = rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      op_load <= 1'b0;
      addr    <= '0;
      funct3  <= '0;
      wdata   <= '0;
      ready   <= 1'b1;
      valid   <= 1'b0;
      err     <= 1'b0;
      rdata   <= ZERO_WORD;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            op_load <= bus.req_is_load;
            addr    <= bus.req_addr;
            funct3  <= bus.req_funct3;
            wdata   <= bus.req_wdata;
            ready   <= 1'b0;
            if (lsu_req_err(bus.req_is_load, bus.req_is_store,
                            bus.req_funct3, bus.req_addr[1:0])) begin
              valid <= 1'b1;
              err   <= 1'b1;
              state <= S_RESP;
            end else begin
              state <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (op_load) begin
            state <= S_WAIT;
          end else begin
            valid <= 1'b1;
            state <= S_RESP;
          end
        end
        S_WAIT: begin
          rdata <= ld_data;
          valid <= 1'b1;
          state <= S_RESP;
        end
        S_RESP: begin
          if (bus.resp_ready) begin
            valid <= 1'b0;
            err   <= 1'b0;
            rdata <= ZERO_WORD;
            ready <= 1'b1;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ysyx_23060332_lsu.sv
// ---------------------------------------------------------------------------
// tb_ysyx_23060332_lsu : directed scoreboard bench with a registered memory model
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ysyx_23060332_lsu;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nren;
    int          nwen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [7:0]  wmask;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem [0:15];

  ysyx_23060332_lsu_if #(.ADDR_W(32), .DATA_W(32), .MASK_W(8)) bus ();

  ysyx_23060332_lsu #(.ADDR_W(32), .DATA_W(32), .MASK_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Single-cycle registered memory: rdata appears the cycle after ren.
  always @(posedge clk) begin
    if (bus.mem_ren) bus.mem_rdata <= mem[bus.mem_raddr[5:2]];
    if (bus.mem_wen) begin
      for (int i = 0; i < 4; i++)
        if (bus.mem_wmask[i]) mem[bus.mem_waddr[5:2]][8*i +: 8] <= bus.mem_wdata[8*i +: 8];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] rd, input logic er, input int lat,
                              input int nr, input int nw, input logic [31:0] ad,
                              input logic [31:0] wd, input logic [7:0] wm);
    exp_t e;
    e.rdata = rd; e.err = er; e.lat = lat; e.nren = nr; e.nwen = nw;
    e.addr = ad; e.wdata = wd; e.wmask = wm;
    return e;
  endfunction

  task automatic txn(input string tag, input logic ld, input logic st, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd, input exp_t e, input int hold);
    exp_t        x;
    int          k = 0;
    bit          got = 1'b0;
    int          nren = 0;
    int          nwen = 0;
    logic [31:0] sa = '0;
    logic [31:0] sd = '0;
    logic [7:0]  sm = '0;
    logic [31:0] rd = '0;
    logic        er = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_is_load = ld; bus.req_is_store = st;
    bus.req_funct3 = f3; bus.req_addr = a; bus.req_wdata = wd;
    chk({tag, ".req_ready"}, 32'(bus.req_ready), 32'd1);
    sb.push_back(e);
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.req_is_load = 1'b0; bus.req_is_store = 1'b0;
    while (!got && k < 20) begin
      @(negedge clk);
      k++;
      if (bus.mem_ren) begin nren++; sa = bus.mem_raddr; end
      if (bus.mem_wen) begin nwen++; sa = bus.mem_waddr; sd = bus.mem_wdata; sm = bus.mem_wmask; end
      if (bus.resp_valid) begin got = 1'b1; rd = bus.resp_rdata; er = bus.resp_err; end
    end
    x = sb.pop_front();
    chk({tag, ".latency"}, got ? 32'(k) : 32'hFFFF_FFFF, 32'(x.lat));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (bus.mem_ren) nren++;
      if (bus.mem_wen) nwen++;
      chk({tag, ".hold_valid"}, 32'(bus.resp_valid), 32'd1);
      chk({tag, ".hold_rdata"}, bus.resp_rdata, x.rdata);
      chk({tag, ".hold_ready"}, 32'(bus.req_ready), 32'd0);
    end
    @(negedge clk);
    bus.resp_ready = 1'b1;
    chk({tag, ".hs_ready"}, 32'(bus.req_ready), 32'd0);
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    @(negedge clk);
    chk({tag, ".post_valid"}, 32'(bus.resp_valid), 32'd0);
    chk({tag, ".post_ready"}, 32'(bus.req_ready), 32'd1);
    chk({tag, ".rdata"}, rd, x.rdata);
    chk({tag, ".err"}, 32'(er), 32'(x.err));
    chk({tag, ".nren"}, 32'(nren), 32'(x.nren));
    chk({tag, ".nwen"}, 32'(nwen), 32'(x.nwen));
    chk({tag, ".addr"}, sa, x.addr);
    chk({tag, ".wdata"}, sd, x.wdata);
    chk({tag, ".wmask"}, 32'(sm), 32'(x.wmask));
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_is_load = 1'b0; bus.req_is_store = 1'b0;
    bus.req_funct3 = 3'b000; bus.req_addr = '0; bus.req_wdata = '0;
    bus.resp_ready = 1'b0; bus.mem_rdata = '0;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mem[4] = 32'h8899_AABB;
    mem[5] = 32'h1122_7F44;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst.req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst.resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst.resp_err", 32'(bus.resp_err), 32'd0);
    chk("rst.resp_rdata", bus.resp_rdata, 32'd0);
    chk("rst.strobes", {30'd0, bus.mem_ren, bus.mem_wen}, 32'd0);
    chk("rst.addrs", bus.mem_raddr | bus.mem_waddr, 32'd0);
    chk("rst.wdata", bus.mem_wdata, 32'd0);
    chk("rst.wmask", 32'(bus.mem_wmask), 32'd0);

    // Loads
    txn("lb_13",  1, 0, 3'b000, 32'h8000_0013, 0, mk(32'hFFFF_FF88, 0, 3, 1, 0, 32'h8000_0010, 0, 0), 0);
    txn("lhu_12", 1, 0, 3'b101, 32'h8000_0012, 0, mk(32'h0000_8899, 0, 3, 1, 0, 32'h8000_0010, 0, 0), 0);
    txn("lw_10",  1, 0, 3'b010, 32'h8000_0010, 0, mk(32'h8899_AABB, 0, 3, 1, 0, 32'h8000_0010, 0, 0), 0);
    txn("lbu_10", 1, 0, 3'b100, 32'h8000_0010, 0, mk(32'h0000_00BB, 0, 3, 1, 0, 32'h8000_0010, 0, 0), 0);
    txn("lh_10",  1, 0, 3'b001, 32'h8000_0010, 0, mk(32'hFFFF_AABB, 0, 3, 1, 0, 32'h8000_0010, 0, 0), 0);
    txn("lbu_13", 1, 0, 3'b100, 32'h8000_0013, 0, mk(32'h0000_0088, 0, 3, 1, 0, 32'h8000_0010, 0, 0), 0);
    txn("lb_16",  1, 0, 3'b000, 32'h8000_0016, 0, mk(32'h0000_0022, 0, 3, 1, 0, 32'h8000_0014, 0, 0), 0);
    txn("lh_14",  1, 0, 3'b001, 32'h8000_0014, 0, mk(32'h0000_7F44, 0, 3, 1, 0, 32'h8000_0014, 0, 0), 0);

    // Stores with read-back
    txn("sb_11",  0, 1, 3'b000, 32'h8000_0011, 32'h0000_00CC, mk(0, 0, 2, 0, 1, 32'h8000_0010, 32'h0000_CC00, 8'h02), 0);
    txn("lw_sb",  1, 0, 3'b010, 32'h8000_0010, 0, mk(32'h8899_CCBB, 0, 3, 1, 0, 32'h8000_0010, 0, 0), 0);
    txn("sh_12",  0, 1, 3'b001, 32'h8000_0012, 32'h0000_1234, mk(0, 0, 2, 0, 1, 32'h8000_0010, 32'h1234_0000, 8'h0C), 0);
    txn("lw_sh",  1, 0, 3'b010, 32'h8000_0010, 0, mk(32'h1234_CCBB, 0, 3, 1, 0, 32'h8000_0010, 0, 0), 0);
    txn("sw_14",  0, 1, 3'b010, 32'h8000_0014, 32'hDEAD_BEEF, mk(0, 0, 2, 0, 1, 32'h8000_0014, 32'hDEAD_BEEF, 8'h0F), 0);
    txn("lw_sw",  1, 0, 3'b010, 32'h8000_0014, 0, mk(32'hDEAD_BEEF, 0, 3, 1, 0, 32'h8000_0014, 0, 0), 0);

    // Errors: no memory access, response the cycle after accept
    txn("e_lw_02",  1, 0, 3'b010, 32'h8000_0002, 0, mk(0, 1, 1, 0, 0, 0, 0, 0), 0);
    txn("e_ld_011", 1, 0, 3'b011, 32'h8000_0010, 0, mk(0, 1, 1, 0, 0, 0, 0, 0), 0);
    txn("e_both",   1, 1, 3'b010, 32'h8000_0010, 0, mk(0, 1, 1, 0, 0, 0, 0, 0), 0);
    txn("e_none",   0, 0, 3'b010, 32'h8000_0010, 0, mk(0, 1, 1, 0, 0, 0, 0, 0), 0);
    txn("e_st_100", 0, 1, 3'b100, 32'h8000_0010, 32'h55, mk(0, 1, 1, 0, 0, 0, 0, 0), 0);
    txn("e_lh_11",  1, 0, 3'b001, 32'h8000_0011, 0, mk(0, 1, 1, 0, 0, 0, 0, 0), 0);
    txn("e_sh_13",  0, 1, 3'b001, 32'h8000_0013, 32'h77, mk(0, 1, 1, 0, 0, 0, 0, 0), 0);
    txn("e_sw_12",  0, 1, 3'b010, 32'h8000_0012, 32'h99, mk(0, 1, 1, 0, 0, 0, 0, 0), 0);

    // Backpressure: writeback stalls for five cycles
    txn("bp_lw",  1, 0, 3'b010, 32'h8000_0010, 0, mk(32'h1234_CCBB, 0, 3, 1, 0, 32'h8000_0010, 0, 0), 5);

    // Reset while waiting for read data aborts the load
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_is_load = 1'b1; bus.req_is_store = 1'b0;
    bus.req_funct3 = 3'b010; bus.req_addr = 32'h8000_0010;
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.req_is_load = 1'b0;
    @(negedge clk);
    chk("abort.ren", 32'(bus.mem_ren), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort.req_ready", 32'(bus.req_ready), 32'd1);
    chk("abort.resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("abort.strobes", {30'd0, bus.mem_ren, bus.mem_wen}, 32'd0);
    @(negedge clk);
    chk("abort.idle_valid", 32'(bus.resp_valid), 32'd0);
    txn("lw_after", 1, 0, 3'b010, 32'h8000_0014, 0, mk(32'hDEAD_BEEF, 0, 3, 1, 0, 32'h8000_0014, 0, 0), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
